display_scan_ctrl: RTL and testbench

//   Time-multiplexes four BCD digits (mm:ss) onto the shared 4-digit 7-segment display.

---
 rtl/display_scan_ctrl.sv | 120 ++++++++++++
 tb/tb_display_scan_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed mm:ss scan controller for a shared 4-digit 7-segment display.
// Each slot starts with an all-off dead time, then lights one anode for the latched digit.
module display_scan_ctrl #(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned DEAD_CYCLES = 16,
  parameter int unsigned BLINK_DIV   = 25000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] sec_bot,
  input  logic [3:0] sec_top,
  input  logic [3:0] min_bot,
  input  logic [3:0] min_top,
  input  logic [3:0] blink_en,
  input  logic       blank_lead,
  output logic [3:0] digit,
  output logic [3:0] an
);

  localparam int unsigned SW = $clog2(REFRESH_DIV);
  localparam int unsigned BW = $clog2(BLINK_DIV);

  localparam logic [SW-1:0] SlotLast  = SW'(REFRESH_DIV - 1);
  localparam logic [SW-1:0] DeadLast  = SW'(DEAD_CYCLES - 1);
  localparam logic [BW-1:0] BlinkLast = BW'(BLINK_DIV - 1);

  localparam logic [0:0] StDead = 1'b0;
  localparam logic [0:0] StShow = 1'b1;

  logic [SW-1:0] slot_cnt_q, slot_cnt_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_ph_q, blink_ph_d;
  logic [1:0]    idx_q, idx_d;
  logic [0:0]    state_q, state_d;
  logic [3:0]    digit_q, digit_d;
  logic [3:0]    an_q, an_d;

  logic [3:0]    sel_val;
  logic [3:0]    cur_val;
  logic          supp;

  always_comb begin
    sel_val = 4'd0;
    unique case (idx_q)
      2'd0: sel_val = sec_bot;
      2'd1: sel_val = sec_top;
      2'd2: sel_val = min_bot;
      2'd3: sel_val = min_top;
      default: sel_val = 4'd0;
    endcase
  end

  // With a single dead cycle the digit register has not been loaded yet when
  // suppression is decided, so fall back to the live selection on slot_cnt==0.
  assign cur_val = (slot_cnt_q == '0) ? sel_val : digit_q;

  assign supp = (cur_val > 4'd9) ||
                (blink_en[idx_q] && blink_ph_q) ||
                ((idx_q == 2'd3) && blank_lead && (cur_val == 4'd0));

  always_comb begin
    blink_cnt_d = blink_cnt_q + BW'(1);
    blink_ph_d  = blink_ph_q;
    if (blink_cnt_q == BlinkLast) begin
      blink_cnt_d = '0;
      blink_ph_d  = ~blink_ph_q;
    end
  end

  always_comb begin
    slot_cnt_d = slot_cnt_q + SW'(1);
    idx_d      = idx_q;
    state_d    = state_q;
    digit_d    = digit_q;
    an_d       = an_q;
    unique case (state_q)
      StDead: begin
        an_d = 4'b1111;
        if (slot_cnt_q == '0) digit_d = sel_val;
        if (slot_cnt_q == DeadLast) begin
          state_d = StShow;
          an_d    = supp ? 4'b1111 : ~(4'b0001 << idx_q);
        end
      end
      StShow: begin
        if (slot_cnt_q == SlotLast) begin
          slot_cnt_d = '0;
          idx_d      = idx_q + 2'd1;
          state_d    = StDead;
          an_d       = 4'b1111;
        end
      end
      default: state_d = StDead;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_cnt_q  <= '0;
      blink_cnt_q <= '0;
      blink_ph_q  <= 1'b0;
      idx_q       <= 2'd0;
      state_q     <= StDead;
      digit_q     <= 4'd0;
      an_q        <= 4'b1111;
    end else begin
      slot_cnt_q  <= slot_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      blink_ph_q  <= blink_ph_d;
      idx_q       <= idx_d;
      state_q     <= state_d;
      digit_q     <= digit_d;
      an_q        <= an_d;
    end
  end

  assign digit = digit_q;
  assign an    = an_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Scoreboard bench for display_scan_ctrl: per-slot directed vectors push the expected
// anode/digit pair; a monitor process pops and checks it as each slot is displayed.
module tb_display_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] sec_bot = 4'd0;
  logic [3:0] sec_top = 4'd0;
  logic [3:0] min_bot = 4'd0;
  logic [3:0] min_top = 4'd0;
  logic [3:0] blink_en = 4'd0;
  logic       blank_lead = 1'b0;
  logic [3:0] digit;
  logic [3:0] an;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [3:0] sb, st, mb, mt, ben;
    logic       bl;
    logic       mid;
    logic [3:0] mid_sb;
    logic [3:0] ean, edig;
  } vec_t;

  typedef struct {
    logic [3:0] an;
    logic [3:0] dig;
  } exp_t;

  vec_t vecs[$];
  exp_t sbq[$];

  display_scan_ctrl #(
    .REFRESH_DIV(8),
    .DEAD_CYCLES(2),
    .BLINK_DIV  (64)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sec_bot   (sec_bot),
    .sec_top   (sec_top),
    .min_bot   (min_bot),
    .min_top   (min_top),
    .blink_en  (blink_en),
    .blank_lead(blank_lead),
    .digit     (digit),
    .an        (an)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int tag, input logic [3:0] act,
                       input logic [3:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s (slot %0d): got %b required %b at t=%0t", name, tag, act, req, $time);
    end
  endtask

  task automatic add(input logic [3:0] sb, st, mb, mt, ben, input logic bl,
                     input logic mid, input logic [3:0] msb, ean, edig);
    vec_t v;
    v.sb = sb; v.st = st; v.mb = mb; v.mt = mt; v.ben = ben; v.bl = bl;
    v.mid = mid; v.mid_sb = msb; v.ean = ean; v.edig = edig;
    vecs.push_back(v);
  endtask

  // One full frame of 7,2,3,4 with nothing suppressed.
  task automatic add_frame(input logic [3:0] ben);
    add(7, 2, 3, 4, ben, 0, 0, 0, 4'b1110, 7);
    add(7, 2, 3, 4, ben, 0, 0, 0, 4'b1101, 2);
    add(7, 2, 3, 4, ben, 0, 0, 0, 4'b1011, 3);
    add(7, 2, 3, 4, ben, 0, 0, 0, 4'b0111, 4);
  endtask

  task automatic run_stim(input int first, input int last);
    for (int i = first; i < last; i++) begin
      sec_bot    = vecs[i].sb;
      sec_top    = vecs[i].st;
      min_bot    = vecs[i].mb;
      min_top    = vecs[i].mt;
      blink_en   = vecs[i].ben;
      blank_lead = vecs[i].bl;
      sbq.push_back('{an: vecs[i].ean, dig: vecs[i].edig});
      repeat (4) @(posedge clk);
      #1;
      if (vecs[i].mid) sec_bot = vecs[i].mid_sb;
      repeat (4) @(posedge clk);
      #1;
    end
  endtask

  task automatic monitor(input int base, input int n);
    exp_t e;
    for (int s = 0; s < n; s++) begin
      for (int k = 0; k < 8; k++) begin
        @(negedge clk);
        if (k < 2) begin
          check("dead_an", base + s, an, 4'b1111);
        end else if (k == 2) begin
          if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_empty (slot %0d): got no entry required one", base + s);
            e = '{an: 4'b1111, dig: 4'd0};
          end else begin
            e = sbq.pop_front();
          end
          check("show_an", base + s, an, e.an);
          check("show_digit", base + s, digit, e.dig);
        end else if (k == 7) begin
          check("hold_an", base + s, an, e.an);
          check("hold_digit", base + s, digit, e.dig);
        end
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "bench timeout");
  end

  initial begin
    // Slot 0 after release, then scan order with 1,2,3,4.
    add(5, 0, 0, 0, 0, 0, 0, 0, 4'b1110, 5);
    add(1, 2, 3, 4, 0, 0, 0, 0, 4'b1101, 2);
    add(1, 2, 3, 4, 0, 0, 0, 0, 4'b1011, 3);
    add(1, 2, 3, 4, 0, 0, 0, 0, 4'b0111, 4);
    add(1, 2, 3, 4, 0, 0, 0, 0, 4'b1110, 1);
    add(1, 2, 3, 4, 0, 0, 0, 0, 4'b1101, 2);
    add(1, 2, 3, 4, 0, 0, 0, 0, 4'b1011, 3);
    add(1, 2, 3, 4, 0, 0, 0, 0, 4'b0111, 4);
    // Slot 8: sec_bot changes 1->7 mid-SHOW; shown at slot 12.
    add(1, 2, 3, 4, 0, 0, 1, 7, 4'b1110, 1);
    add(7, 2, 3, 4, 0, 0, 0, 0, 4'b1101, 2);
    add(7, 2, 3, 4, 0, 0, 0, 0, 4'b1011, 3);
    add(7, 2, 3, 4, 0, 0, 0, 0, 4'b0111, 4);
    add(7, 2, 3, 4, 0, 0, 0, 0, 4'b1110, 7);
    // Blink slot 2: phase is 1 for slots 8..15 and 24..31.
    add(7, 2, 3, 4, 4'b0100, 0, 0, 0, 4'b1101, 2);
    add(7, 2, 3, 4, 4'b0100, 0, 0, 0, 4'b1111, 3);
    add(7, 2, 3, 4, 4'b0100, 0, 0, 0, 4'b0111, 4);
    add_frame(4'b0100);
    add_frame(4'b0100);
    add(7, 2, 3, 4, 4'b0100, 0, 0, 0, 4'b1110, 7);
    add(7, 2, 3, 4, 4'b0100, 0, 0, 0, 4'b1101, 2);
    add(7, 2, 3, 4, 4'b0100, 0, 0, 0, 4'b1111, 3);
    add(7, 2, 3, 4, 4'b0100, 0, 0, 0, 4'b0111, 4);
    add(7, 2, 3, 4, 4'b0100, 0, 0, 0, 4'b1110, 7);
    add(7, 2, 3, 4, 4'b0100, 0, 0, 0, 4'b1101, 2);
    add(7, 2, 3, 4, 4'b0100, 0, 0, 0, 4'b1111, 3);
    add(7, 2, 3, 4, 4'b0100, 0, 0, 0, 4'b0111, 4);
    add(7, 2, 3, 4, 4'b0100, 0, 0, 0, 4'b1110, 7);
    add(7, 2, 3, 4, 4'b0100, 0, 0, 0, 4'b1101, 2);
    add(7, 2, 3, 4, 4'b0100, 0, 0, 0, 4'b1011, 3);
    // Leading-zero blanking and invalid BCD.
    add(7, 2, 3, 0, 0, 1, 0, 0, 4'b1111, 0);
    add(7, 2, 3, 0, 0, 1, 0, 0, 4'b1110, 7);
    add(7, 2, 3, 0, 0, 1, 0, 0, 4'b1101, 2);
    add(7, 2, 3, 0, 0, 1, 0, 0, 4'b1011, 3);
    add(7, 2, 3, 0, 0, 0, 0, 0, 4'b0111, 0);
    add(7, 2, 3, 0, 0, 0, 0, 0, 4'b1110, 7);
    add(7, 2, 3, 0, 0, 0, 0, 0, 4'b1101, 2);
    add(7, 2, 3, 0, 0, 0, 0, 0, 4'b1011, 3);
    add(7, 2, 3, 4'hA, 0, 0, 0, 0, 4'b1111, 4'hA);
    add(7, 2, 3, 4'hA, 0, 1, 0, 0, 4'b1110, 7);
    add(7, 2, 3, 4'hA, 0, 1, 0, 0, 4'b1101, 2);
    add(7, 2, 3, 4'hA, 0, 1, 0, 0, 4'b1011, 3);
    add(7, 2, 3, 4'hA, 0, 1, 0, 0, 4'b1111, 4'hA);
    add(4'hF, 2, 3, 4, 0, 1, 0, 0, 4'b1111, 4'hF);
    add(7, 2, 3, 4, 0, 1, 0, 0, 4'b1101, 2);
    add(7, 2, 3, 4, 0, 1, 0, 0, 4'b1011, 3);
    add(7, 2, 3, 4, 0, 1, 0, 0, 4'b0111, 4);
    add(7, 2, 3, 4, 0, 1, 0, 0, 4'b1110, 7);
    add(7, 2, 3, 4, 0, 1, 0, 0, 4'b1101, 2);
    // After the mid-slot reset: scan restarts at slot 0.
    add(9, 8, 6, 0, 0, 1, 0, 0, 4'b1110, 9);
    add(9, 8, 6, 0, 0, 1, 0, 0, 4'b1101, 8);
    add(9, 8, 6, 0, 0, 1, 0, 0, 4'b1011, 6);
    add(9, 8, 6, 0, 0, 1, 0, 0, 4'b1111, 0);
    add(9, 8, 6, 0, 0, 1, 0, 0, 4'b1110, 9);

    repeat (3) @(posedge clk);
    #1;
    check("reset_an", -1, an, 4'b1111);
    check("reset_digit", -1, digit, 4'd0);

    rst = 1'b0;
    fork
      run_stim(0, 54);
      monitor(0, 54);
    join

    // Now at the start of slot 54 (index 2); reset asynchronously during its SHOW.
    repeat (4) @(posedge clk);
    #1;
    check("pre_reset_an", 54, an, 4'b1011);
    #2;
    rst = 1'b1;
    #1;
    check("async_reset_an", 54, an, 4'b1111);
    check("async_reset_digit", 54, digit, 4'd0);

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    fork
      run_stim(54, 59);
      monitor(100, 5);
    join

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
